// File: rtl/oled_update_scheduler.sv
// Queues I2C-received bytes and issues them one at a time to the OLED controller
// over its EN/FIN handshake, enforcing an inter-update gap and a completion timeout.
module oled_update_scheduler #(
    parameter int FIFO_AW = 3,
    parameter int MIN_GAP = 1000,
    parameter int TIMEOUT = 10_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               oled_en,
    output logic [7:0]         oled_data,
    input  logic               oled_fin,
    input  logic               clr_err,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow,
    output logic               timeout
);

    // state    | meaning
    // S_IDLE   | oled_en low; pops head when FIFO not empty
    // S_WAIT   | oled_en high, byte held; waiting for FIN or timeout
    // S_GAP    | oled_en low; enforcing MIN_GAP and waiting for FIN release
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int                 DEPTH_I  = 1 << FIFO_AW;
    localparam int                 GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [FIFO_AW:0]   DEPTH    = (FIFO_AW+1)'(DEPTH_I);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [GW-1:0]      GAP_LAST = GW'(MIN_GAP - 1);
    localparam logic [23:0]        TO_LAST  = 24'(TIMEOUT - 1);

    logic [7:0]         r_mem [DEPTH_I];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [1:0]         r_state;
    logic [23:0]        r_timer;
    logic [GW-1:0]      r_gap;
    logic               r_en;
    logic [7:0]         r_data;
    logic               r_busy;
    logic               r_ovf;
    logic               r_to;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_to_hit;

    assign w_full   = (r_count == DEPTH);
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
    // A full FIFO still accepts a byte when a slot frees up in the same cycle.
    assign w_push   = rx_valid && (!w_full || w_pop);
    assign w_drop   = rx_valid && w_full && !w_pop;
    assign w_to_hit = (r_state == S_WAIT) && !oled_fin && (r_timer == TO_LAST);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_gap   <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_data  <= r_mem[r_rptr];
                        r_en    <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (oled_fin || w_to_hit) begin
                        r_en    <= 1'b0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_GAP: begin
                    if ((r_gap == GAP_LAST) && !oled_fin) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gap != GAP_LAST) begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
            // A timeout in the same cycle as a clear must stay visible.
            if (w_to_hit) begin
                r_to <= 1'b1;
            end else if (clr_err) begin
                r_to <= 1'b0;
            end
        end
    end

    assign oled_en    = r_en;
    assign oled_data  = r_data;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;
    assign timeout    = r_to;

endmodule
